// File: rtl/expr_eval_if.sv
// Character-stream interface between a character source and the expression evaluator.
// master drives characters; slave (the evaluator) returns status and the running value.
interface expr_eval_if #(
    parameter int W = 16
) ();
    logic         in_valid;
    logic [7:0]   in;
    logic         out;
    logic [W-1:0] value;
    logic         done;
    logic         err;

    modport master (output in_valid, in, input out, value, done, err);
    modport slave  (input in_valid, in, output out, value, done, err);
endinterface

// File: rtl/expr_eval.sv
// Streaming ASCII evaluator for expressions like "12+3*4=" with * above +/-, all mod 2^W.
// Optional macro EXPR_SPACE_EN: when defined, ASCII spaces are skipped in every state.
module expr_eval #(
    parameter int W          = 16,
    parameter int MAX_DIGITS = 5
) (
    input  logic        clk,
    input  logic        clr_n,
    expr_eval_if.slave  bus
);
    localparam int CW = $clog2(MAX_DIGITS + 1);

    typedef enum logic [2:0] {IDLE, NUM, OP, DONE, ERR} state_t;

    state_t         state_reg, state_next;
    logic [W-1:0]   acc_reg, acc_next;
    logic [W-1:0]   prod_reg, prod_next;
    logic [W-1:0]   num_reg, num_next;
    logic           neg_reg, neg_next;
    logic [CW-1:0]  count_reg, count_next;
    logic           done_reg, done_next;

    logic [7:0]     ch;
    logic           is_digit, is_mul, is_add, is_sub, is_eq, skip;
    logic [W-1:0]   digit, term, value_comb;

    assign ch       = bus.in;
    assign is_digit = (ch >= 8'h30) && (ch <= 8'h39);
    assign is_mul   = (ch == 8'h2A);
    assign is_add   = (ch == 8'h2B);
    assign is_sub   = (ch == 8'h2D);
    assign is_eq    = (ch == 8'h3D);
    assign digit    = W'(ch[3:0]);

`ifdef EXPR_SPACE_EN
    assign skip = (ch == 8'h20);
`else
    assign skip = 1'b0;
`endif

    // Pending product term folds into the accumulator only when +/- arrives.
    assign term       = prod_reg * num_reg;
    assign value_comb = neg_reg ? (acc_reg - term) : (acc_reg + term);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            prod_reg  <= W'(1);
            num_reg   <= '0;
            neg_reg   <= 1'b0;
            count_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            prod_reg  <= prod_next;
            num_reg   <= num_next;
            neg_reg   <= neg_next;
            count_reg <= count_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        prod_next  = prod_reg;
        num_next   = num_reg;
        neg_next   = neg_reg;
        count_next = count_reg;
        done_next  = 1'b0;

        if (bus.in_valid && !skip) begin
            case (state_reg)
                ERR: begin
                    if (is_eq) begin
                        state_next = IDLE;
                        acc_next   = '0;
                        prod_next  = W'(1);
                        num_next   = '0;
                        neg_next   = 1'b0;
                        count_next = '0;
                    end
                end
                NUM: begin
                    if (is_digit) begin
                        if (count_reg < CW'(MAX_DIGITS)) begin
                            num_next   = num_reg * W'(10) + digit;
                            count_next = count_reg + CW'(1);
                        end else begin
                            state_next = ERR;
                        end
                    end else if (is_mul) begin
                        prod_next  = term;
                        num_next   = '0;
                        state_next = OP;
                    end else if (is_add || is_sub) begin
                        acc_next   = value_comb;
                        prod_next  = W'(1);
                        num_next   = '0;
                        neg_next   = is_sub;
                        state_next = OP;
                    end else if (is_eq) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = ERR;
                    end
                end
                default: begin
                    if (is_digit) begin
                        num_next   = digit;
                        count_next = CW'(1);
                        state_next = NUM;
                        // A digit after '=' begins a brand-new expression.
                        if (state_reg == DONE) begin
                            acc_next  = '0;
                            prod_next = W'(1);
                            neg_next  = 1'b0;
                        end
                    end else if (!(is_eq && state_reg == DONE)) begin
                        state_next = ERR;
                    end
                end
            endcase
        end
    end

    assign bus.out   = (state_reg == NUM) || (state_reg == DONE);
    assign bus.value = value_comb;
    assign bus.done  = done_reg;
    assign bus.err   = (state_reg == ERR);
endmodule

// File: doc/expr_eval.md
Name: expr_eval

Overview:
- Streaming ASCII arithmetic-expression recogniser and evaluator; successor to the single-digit expression FSM.
- Accepts one character per accepted cycle.
- Supports multi-digit unsigned operands, operators + - * with standard precedence (* binds tighter), and an '=' terminator.
- Reports syntactic validity, running value (mod 2^W), completion pulse and sticky error; sits between a character source (UART/testbench) and display/compare logic.

Parameters:
W, 16, width of value and all arithmetic registers; all arithmetic mod 2^W.
MAX_DIGITS, 5, max digits per operand; digit MAX_DIGITS+1 is an error.

Ports:
clk  input  1  clock, rising edge.
clr_n  input  1  asynchronous, active-low reset.
in_valid  input  1  in is sampled only when 1; else the cycle is a stall (no state change).
in  input  8  ASCII character.
out  output  1  1 when characters so far form a complete valid expression (state NUM or DONE).
value  output  W  current value: acc + sign*(prod*num), mod 2^W, two's complement.
done  output  1  one-cycle pulse after '=' accepted in NUM.
err  output  1  1 while in state ERR.

Behaviour:
- Reset (clr_n=0, async): state IDLE, acc=0, prod=1, num=0, sign=+, digit count=0; out=0, value=0, done=0, err=0. Reset mid-expression discards everything.
- Latency: char accepted at edge k; out/value/done/err reflect it immediately after edge k (registered state, value combinational from registers).
- States: IDLE (expect first operand), NUM (inside operand), OP (after operator, expect operand), DONE (after '='), ERR.
- Digit '0'-'9' in IDLE/OP/DONE: num=d, count=1 -> NUM. DONE first resets acc=0, prod=1, sign=+ (new expression).
- Digit in NUM: count<MAX_DIGITS -> num=num*10+d (mod 2^W), count++; else -> ERR.
- '*' in NUM: prod=prod*num, num=0 -> OP.
- '+'/'-' in NUM: acc=acc+sign*(prod*num), prod=1, num=0, sign=+/- -> OP.
- Operator in IDLE/OP/DONE -> ERR.
- '=' in NUM: acc, prod, num frozen -> DONE, done=1 for exactly that cycle; value held.
- '=' in IDLE/OP -> ERR. '=' in DONE: ignored, no new done pulse.
- ERR: every char except '=' ignored; '=' in ERR -> IDLE with all registers at reset values (resync); err clears the same edge.
- Any other character (letters, etc.) in any non-ERR state -> ERR.
- Leading zeros legal ("007" = 7, counts 3 digits).
- in_valid=0: all registers hold; done drops after one cycle regardless of in_valid.

Optional Feature:
EXPR_SPACE_EN:
- Defined: ASCII space (0x20) with in_valid=1 is ignored in all states; no state change, no digit count, does not end an operand's digit sequence for overflow purposes. "1 2" therefore = 12.
- Undefined: space treated as an illegal character -> ERR.

Test Plan:
- Reset, then "12+3*4=" one char/cycle -> after '4': out=1, value=24; after '=': done=1 one cycle, out=1, value=24; next cycle done=0.
- "7-2*3=" -> value=1. "2-5=" -> value=16'hFFFD, out=1.
- "1+*" -> err=1, out=0 after '*'; further "5" ignored (err stays 1); '=' -> err=0, IDLE, value=0; then "9=" -> value=9, done pulse.
- MAX_DIGITS=5: "12345" -> out=1, value=12345; sixth digit "6" -> err=1.
- "3*4" with in_valid low 3 cycles between '*' and '4' -> value=0 during stall, out=0; value=12 after '4'. Assert clr_n=0 mid "12+" -> all outputs 0 asynchronously, before the next clk edge.
- "5=" then "8*2=" -> second expression starts fresh, value=16 (not 5-based); "a" in IDLE -> err=1. With EXPR_SPACE_EN: "1 + 2=" -> value=3; without: err after first space.
